// File: rtl/dsp_pkg.sv
// Shared widths and pipeline constants for the pre-add / multiply / accumulate slice.
package dsp_pkg;

   localparam int AD_W    = 9;   // A and D operands
   localparam int PRE_W   = 10;  // pre-adder result A - D
   localparam int B_W     = 8;   // coefficient
   localparam int M_W     = 18;  // product
   localparam int ACC_W   = 24;  // accumulator / rrC

   localparam int PIPE_DEPTH = 3;  // sample-in to P latency
   localparam int RRC_OFFSET = 2;  // cycle after a load sample at which rrC is taken

   typedef struct packed {
      logic load;
      logic clear;
   } ctrl_t;

   function automatic logic signed [ACC_W-1:0] sext_m(input logic signed [M_W-1:0] m);
      return {{(ACC_W-M_W){m[M_W-1]}}, m};
   endfunction

endpackage

// File: rtl/dsp.sv
// (A - D) x B pipelined MAC with clear / load-from-rrC / accumulate and a tag
// pipeline marking the cycle P holds a finished row sum. Shaped for one DSP slice.
module dsp
   import dsp_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    clear,
   input  logic                    idelay,
   input  logic signed [AD_W-1:0]  A,
   input  logic signed [B_W-1:0]   B,
   input  logic signed [ACC_W-1:0] rrC,
   input  logic signed [AD_W-1:0]  D,
   output logic signed [ACC_W-1:0] P,
   output logic                    odelay_pre1,
   output logic                    odelay
);

   logic signed [AD_W-1:0]  a_q, d_q;
   logic signed [B_W-1:0]   b1_q, b2_q;
   ctrl_t                   ctrl1_q, ctrl2_q;
   logic signed [PRE_W-1:0] ad_d, ad_q;
   logic signed [M_W-1:0]   m;
   logic signed [ACC_W-1:0] p_d, p_q;
   logic [PIPE_DEPTH-1:0]   tag_q;

   always_comb begin
      ad_d = {a_q[AD_W-1], a_q} - {d_q[AD_W-1], d_q};
      m    = ad_q * b2_q;
   end

   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      p_d = p_q + sext_m(m);
      if (ctrl2_q.clear)
         p_d = sext_m(m);
      else if (ctrl2_q.load)
         p_d = rrC + sext_m(m);
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q     <= '0;
         d_q     <= '0;
         b1_q    <= '0;
         b2_q    <= '0;
         ctrl1_q <= '0;
         ctrl2_q <= '0;
         ad_q    <= '0;
         p_q     <= '0;
         tag_q   <= '0;
      end else begin
         a_q     <= A;
         d_q     <= D;
         b1_q    <= B;
         ctrl1_q <= '{load: load, clear: clear};
         ad_q    <= ad_d;
         b2_q    <= b1_q;
         ctrl2_q <= ctrl1_q;
         p_q     <= p_d;
         tag_q   <= {tag_q[PIPE_DEPTH-2:0], idelay};
      end
   end

   assign P           = p_q;
   assign odelay_pre1 = tag_q[RRC_OFFSET-1];
   assign odelay      = tag_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_dsp.sv
// Directed table-driven bench for dsp plus hand-written reset sequence.
module tb_dsp;

   logic        clk = 1'b0;
   logic        rst;
   logic        load, clear, idelay;
   logic [8:0]  a, d;
   logic [7:0]  b;
   logic [23:0] rrc;
   logic [23:0] p;
   logic        odelay_pre1, odelay;

   int checks = 0;
   int errors = 0;

   dsp dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .clear       (clear),
      .idelay      (idelay),
      .A           (a),
      .B           (b),
      .rrC         (rrc),
      .D           (d),
      .P           (p),
      .odelay_pre1 (odelay_pre1),
      .odelay      (odelay)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        load;
      logic        clear;
      logic        idelay;
      logic [8:0]  a;
      logic [8:0]  d;
      logic [7:0]  b;
      logic [23:0] rrc;
      logic [23:0] exp_p;
      logic        exp_odp;
      logic        exp_od;
   } vec_t;

   localparam int NV = 38;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      load = 0; clear = 0; idelay = 0;
      a = 9'd128; d = 9'd128; b = 8'd0; rrc = 24'd5;
   endtask

   task automatic drive_vec(input vec_t v);
      load = v.load; clear = v.clear; idelay = v.idelay;
      a = v.a; d = v.d; b = v.b; rrc = v.rrc;
   endtask

   task automatic check_outs(input string tag, input logic [23:0] ep, input logic eodp,
                             input logic eod);
      check({tag, " P"}, p, ep);
      check({tag, " odelay_pre1"}, {23'd0, odelay_pre1}, {23'd0, eodp});
      check({tag, " odelay"}, {23'd0, odelay}, {23'd0, eod});
   endtask

   int exp_p_tab [NV];

   initial begin
      // P per cycle: a sample presented in row i shows up in row i+3.
      exp_p_tab = '{0, 0, 0, 8128, 16256, 24384, 32512, 40640, 48768, 56896,
                    65024, 65024, 65024, 65024, 65024,
                    9128, 17256, 25384, 33512, 41640, 49768, 57896, 66024,
                    66024, 66024, 66024,
                    16384, 128, 128, 128, 128,
                    1, 1, 1, 1,
                    24'h800000, 16, 16};

      for (int i = 0; i < NV; i++) begin
         vecs[i] = '{load: 0, clear: 0, idelay: 0, a: 9'd128, d: 9'd128, b: 8'd0,
                     rrc: 24'd5, exp_p: 24'(exp_p_tab[i]), exp_odp: 0, exp_od: 0};
      end
      // identical-sample run, tag on the last pixel
      for (int i = 0; i < 8; i++) begin
         vecs[i].a = 9'd255; vecs[i].b = 8'd64;
      end
      vecs[0].clear  = 1;
      vecs[7].idelay = 1;
      vecs[9].exp_odp = 1;
      vecs[10].exp_od = 1;
      // load path with rrC two cycles after the load sample
      for (int i = 12; i < 20; i++) begin
         vecs[i].a = 9'd255; vecs[i].b = 8'd64;
      end
      vecs[12].load   = 1;
      vecs[14].rrc    = 24'd1000;
      vecs[19].idelay = 1;
      vecs[21].exp_odp = 1;
      vecs[22].exp_od  = 1;
      // negative operands
      vecs[23].clear = 1; vecs[23].a = 9'd0; vecs[23].b = 8'h80;
      vecs[24].a = 9'd0; vecs[24].b = 8'h7F;
      // load and clear together: clear wins
      vecs[28].load = 1; vecs[28].clear = 1; vecs[28].a = 9'd129; vecs[28].b = 8'd1;
      vecs[30].rrc  = 24'd999;
      // wrap, then back-to-back load
      vecs[32].load = 1; vecs[32].a = 9'd129; vecs[32].b = 8'd1;
      vecs[34].rrc  = 24'h7FFFFF;
      vecs[33].load = 1; vecs[33].a = 9'd130; vecs[33].b = 8'd3;
      vecs[35].rrc  = 24'd10;

      rst = 0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 24'd0, 1'b0, 1'b0);
      #4 rst = 1;
      step();

      for (int i = 0; i < NV; i++) begin
         drive_vec(vecs[i]);
         check_outs($sformatf("row%0d", i), vecs[i].exp_p, vecs[i].exp_odp, vecs[i].exp_od);
         step();
      end

      // mid-accumulation async reset with a tag still in flight
      drive_idle();
      clear = 1; a = 9'd255; b = 8'd64;
      step();
      clear = 0;
      step();
      idelay = 1;
      step();
      idelay = 0;
      check("pre-reset P", p, 24'd8128);
      #2 rst = 0;
      #1;
      check_outs("async reset", 24'd0, 1'b0, 1'b0);
      drive_idle();
      @(posedge clk);
      #2 rst = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_outs($sformatf("post-reset%0d", k), 24'd0, 1'b0, 1'b0);
      end
      clear = 1; a = 9'd255; b = 8'd64;
      step();
      drive_idle();
      check("first sample lat1", p, 24'd0);
      step();
      check("first sample lat2", p, 24'd0);
      step();
      check("first sample lat3", p, 24'd8128);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
